firc_feeder: RTL



---
 rtl/firc_feeder_if.sv | 47 ++++
 rtl/firc_feeder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/firc_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// firc_feeder_if : coefficient, source and filter-side signals of firc_feeder
// Revision 1.0
// ---------------------------------------------------------------------------
interface firc_feeder_if #(
  parameter int S_WIDTH = 24,
  parameter int C_WIDTH = 27,
  parameter int N_TAPS  = 16
);
  localparam int A_WIDTH = $clog2(N_TAPS);

  logic               Start;
  logic               CoefValid;
  logic               CoefReady;
  logic [C_WIDTH-1:0] CoefInI;
  logic [C_WIDTH-1:0] CoefInQ;
  logic               SrcValid;
  logic               SrcReady;
  logic [S_WIDTH-1:0] SrcI;
  logic [S_WIDTH-1:0] SrcQ;
  logic               PushCoef;
  logic [A_WIDTH-1:0] CoefAddr;
  logic [C_WIDTH-1:0] CoefI;
  logic [C_WIDTH-1:0] CoefQ;
  logic               PushIn;
  logic [S_WIDTH-1:0] SampI;
  logic [S_WIDTH-1:0] SampQ;
  logic               StopIn;
  logic               CoefLoaded;
  logic [15:0]        SampCount;

  // master: the feeder itself
  modport master (
    input  Start, CoefValid, CoefInI, CoefInQ, SrcValid, SrcI, SrcQ, StopIn,
    output CoefReady, SrcReady, PushCoef, CoefAddr, CoefI, CoefQ,
           PushIn, SampI, SampQ, CoefLoaded, SampCount
  );

  // slave: upstream sources plus the filter
  modport slave (
    output Start, CoefValid, CoefInI, CoefInQ, SrcValid, SrcI, SrcQ, StopIn,
    input  CoefReady, SrcReady, PushCoef, CoefAddr, CoefI, CoefQ,
           PushIn, SampI, SampQ, CoefLoaded, SampCount
  );
endinterface
`default_nettype wire

// File: rtl/firc_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// firc_feeder : loads firc coefficients, then streams samples via a skid FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module firc_feeder #(
  parameter int S_WIDTH    = 24,
  parameter int C_WIDTH    = 27,
  parameter int N_TAPS     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  firc_feeder_if.master bus
);
  localparam int A_WIDTH = $clog2(N_TAPS);
  localparam int P_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(N_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               load_enter;
  logic               coef_ready;
  logic               src_ready;
  logic               coef_hs;
  logic               src_hs;
  logic               pop;
  logic               full;
  logic               empty;

  logic [A_WIDTH-1:0] addr;
  logic               push_coef;
  logic [A_WIDTH-1:0] coef_addr;
  logic [C_WIDTH-1:0] coef_i;
  logic [C_WIDTH-1:0] coef_q;
  logic               coef_loaded;
  logic [15:0]        samp_count;

  // Pointers carry one extra wrap bit to tell full from empty
  logic [P_WIDTH:0]   wr_ptr;
  logic [P_WIDTH:0]   rd_ptr;
  logic [P_WIDTH-1:0] wr_idx;
  logic [P_WIDTH-1:0] rd_idx;
  logic [S_WIDTH-1:0] mem_i [FIFO_DEPTH];
  logic [S_WIDTH-1:0] mem_q [FIFO_DEPTH];

  assign wr_idx = wr_ptr[P_WIDTH-1:0];
  assign rd_idx = rd_ptr[P_WIDTH-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[P_WIDTH] != rd_ptr[P_WIDTH]) && (wr_idx == rd_idx);

  assign coef_hs = coef_ready & bus.CoefValid;
  assign src_hs  = src_ready & bus.SrcValid;
  // StopIn only gates the pop; PushIn itself never looks at it
  assign pop     = !empty & !bus.StopIn;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_enter = 1'b0;
    coef_ready = 1'b0;
    src_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          state_nxt  = LOAD;
          load_enter = 1'b1;
        end
      end
      LOAD: begin
        coef_ready = 1'b1;
        if (bus.CoefValid && (addr == LAST_ADDR)) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        src_ready = !full;
        if (bus.Start) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (empty) begin
          state_nxt  = LOAD;
          load_enter = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr        <= '0;
      push_coef   <= 1'b0;
      coef_addr   <= '0;
      coef_i      <= '0;
      coef_q      <= '0;
      coef_loaded <= 1'b0;
    end else begin
      push_coef <= coef_hs;
      if (load_enter) begin
        addr        <= '0;
        coef_loaded <= 1'b0;
      end else if (coef_hs) begin
        coef_addr <= addr;
        coef_i    <= bus.CoefInI;
        coef_q    <= bus.CoefInQ;
        addr      <= addr + A_WIDTH'(1);
        if (addr == LAST_ADDR) begin
          coef_loaded <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      samp_count <= '0;
    end else begin
      if (src_hs) begin
        wr_ptr <= wr_ptr + (P_WIDTH + 1)'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + (P_WIDTH + 1)'(1);
        samp_count <= samp_count + 16'd1;
      end
    end
  end

  // Storage needs no reset: nothing is visible until the pointers say so
  always_ff @(posedge Clk) begin
    if (src_hs) begin
      mem_i[wr_idx] <= bus.SrcI;
      mem_q[wr_idx] <= bus.SrcQ;
    end
  end

  assign bus.CoefReady  = coef_ready;
  assign bus.SrcReady   = src_ready;
  assign bus.PushCoef   = push_coef;
  assign bus.CoefAddr   = coef_addr;
  assign bus.CoefI      = coef_i;
  assign bus.CoefQ      = coef_q;
  assign bus.CoefLoaded = coef_loaded;
  assign bus.PushIn     = !empty;
  assign bus.SampI      = empty ? '0 : mem_i[rd_idx];
  assign bus.SampQ      = empty ? '0 : mem_q[rd_idx];
  assign bus.SampCount  = samp_count;

endmodule
`default_nettype wire
